fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Control end of the EX-stage operand forwarding path: generates the 2-bit select codes consumed by the 3-input 32-bit operand muxes (ForwardA/ForwardB), plus the load-use stall request.
- Internally tracks destination-register info for the ID/EX, EX/MEM and MEM/WB pipeline slots.
- Select outputs are registered, so they are valid for the whole cycle the instruction occupies EX.
- Sits beside the ID/EX pipeline register in the 5-stage core.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk_i  in  1  core clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- id_valid_i  in  1  ID stage holds a real instruction.
- id_rs1_i  in  5  ID source register 1.
- id_rs2_i  in  5  ID source register 2.
- id_rd_i  in  5  ID destination register.
- id_regwrite_i  in  1  ID instruction writes rd.
- id_memread_i  in  1  ID instruction is a load.
- flush_i  in  1  squash the ID instruction (taken branch); it enters EX as a bubble.
- forward_a_o  out  2  operand A select for the instruction in EX.
- forward_b_o  out  2  operand B select for the instruction in EX.
- stall_o  out  1  load-use stall; upstream holds PC and IF/ID.
- stall_cnt_o  out  CNT_W  number of stall cycles since reset.

Behaviour:
- Select encoding:
  - 2'b00: ID/EX register-file value.
  - 2'b01: MEM/WB write-back data.
  - 2'b10: EX/MEM ALU result.
  - 2'b11: never driven.
- Tracking slots: IDEX, EXMEM, MEMWB. Each holds {v, rd, regwrite, memread}; IDEX also holds rs1 and rs2.
- Every rising edge, unconditionally: MEMWB <= EXMEM, EXMEM <= IDEX.
- IDEX load rule:
  - If stall_o or flush_i, or id_valid_i = 0, IDEX <= bubble (v = 0, regwrite = 0, memread = 0).
  - Otherwise IDEX <= ID inputs.
- Forward select (forward_a_o shown; forward_b_o is identical using rs2):
  - Computed combinationally from the ID inputs and the current IDEX/EXMEM, then registered on the same edge that loads IDEX.
  - Priority 1: if the current IDEX is v & regwrite & rd != 0 & rd == id_rs1_i, select 2'b10 (that instruction is moving to EX/MEM).
  - Priority 2: else if the current EXMEM is v & regwrite & rd != 0 & rd == id_rs1_i, select 2'b01.
  - Otherwise select 2'b00.
  - When IDEX is loaded with a bubble, both selects register 2'b00.
- Youngest producer wins: EX/MEM beats MEM/WB when both match.
- rd = x0 never forwards.
- Register-file WB-to-ID same-cycle hazard is out of scope; the register file is write-through.
- stall_o is combinational:
  - stall_o = id_valid_i & ~flush_i & IDEX.v & IDEX.memread & IDEX.rd != 0 & (IDEX.rd == id_rs1_i | IDEX.rd == id_rs2_i).
  - rs2 is always compared; this is conservative for I-type instructions.
- Stall is one cycle per load-use pair:
  - Next cycle the load sits in EXMEM and IDEX is a bubble, so stall_o drops.
  - The held instruction then registers select 2'b01 for the matching operand.
- flush_i and stall conditions in the same cycle: flush wins, stall_o = 0, IDEX gets a bubble, counter does not increment.
- stall_cnt_o increments on each rising edge where stall_o = 1 and saturates at all-ones (no wrap).
- Reset (asynchronous assert, any time, including mid-stall):
  - All slots invalid.
  - forward_a_o = forward_b_o = 2'b00.
  - stall_o = 0, because it follows the invalid IDEX.
  - stall_cnt_o = 0.
- First edge after reset deassertion behaves as a normal load of IDEX.
- Latency: select for an instruction is available one edge after it is presented in ID, i.e. exactly when it enters EX.

Test Plan:
- Back-to-back ALU dependency:
  - Stimulus: add x5 (rd=5, regwrite) then sub with rs1=5, rs2=6.
  - Required: in the sub's EX cycle, forward_a_o = 2'b10, forward_b_o = 2'b00, stall_o never asserted.
- Distance-2 dependency plus priority:
  - Stimulus: two writers to x7 in a row, then an instruction with rs1=7, rs2=7.
  - Required: both selects = 2'b10. With an unrelated instruction between the single writer and the reader, both selects = 2'b01.
- Load-use:
  - Stimulus: lw x9, then add rs2=9 held valid.
  - Required: stall_o = 1 for exactly one cycle; stall_cnt_o goes 0 -> 1; in the add's EX cycle forward_b_o = 2'b01.
- x0 and bubble rules:
  - Stimulus A: writer with rd=0 followed by a reader with rs1=0. Required: selects 2'b00.
  - Stimulus B: id_valid_i = 0 cycles. Required: selects 2'b00 and no stall.
- Flush vs stall:
  - Stimulus: lw x3 in IDEX; ID instruction uses rs1=3 with flush_i = 1.
  - Required: stall_o = 0, counter unchanged, next-cycle selects 2'b00.
- Async reset mid-stall and saturation:
  - Stimulus: drop rst_i while stall_o = 1, without a clock edge.
  - Required: stall_o, forward_*_o and stall_cnt_o go to 0 immediately.
  - Separately, with CNT_W=2, four stalls leave stall_cnt_o = 2'b11.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage operand forwarding control: registered ForwardA/ForwardB select codes
// and the combinational load-use stall request, with a saturating stall counter.
module fwd_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             flush_i,
  output logic [1:0]       forward_a_o,
  output logic [1:0]       forward_b_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_WB    = 2'b01;
  localparam logic [1:0] SEL_EXMEM = 2'b10;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } idex_t;

  // The MEM/WB view is exactly this slot one edge later; selects are computed a
  // stage early, so no separate MEM/WB register is kept.
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       regwrite;
  } exmem_t;

  localparam idex_t IDEX_BUBBLE = '{v: 1'b0, rd: 5'd0, regwrite: 1'b0, memread: 1'b0};

  idex_t      idex_q;
  exmem_t     exmem_q;
  logic       load_bubble;
  logic [1:0] fwd_a_d;
  logic [1:0] fwd_b_d;

  // True when a slot will deliver a value for register src; x0 never forwards.
  function automatic logic producer_hit(logic v, logic regwrite, logic [4:0] rd,
                                        logic [4:0] src);
    return v & regwrite & (rd != 5'd0) & (rd == src);
  endfunction

  function automatic logic [1:0] select_for(idex_t idex, exmem_t exmem, logic [4:0] src);
    if (producer_hit(idex.v, idex.regwrite, idex.rd, src))
      return SEL_EXMEM;
    else if (producer_hit(exmem.v, exmem.regwrite, exmem.rd, src))
      return SEL_WB;
    else
      return SEL_RF;
  endfunction

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    stall_o     = 1'b0;
    load_bubble = 1'b1;
    fwd_a_d     = SEL_RF;
    fwd_b_d     = SEL_RF;

    stall_o = id_valid_i & ~flush_i & idex_q.v & idex_q.memread & (idex_q.rd != 5'd0) &
              ((idex_q.rd == id_rs1_i) | (idex_q.rd == id_rs2_i));

    load_bubble = stall_o | flush_i | ~id_valid_i;

    if (!load_bubble) begin
      fwd_a_d = select_for(idex_q, exmem_q, id_rs1_i);
      fwd_b_d = select_for(idex_q, exmem_q, id_rs2_i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, making EXMEM <= IDEX a true shift.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idex_q      <= IDEX_BUBBLE;
      exmem_q     <= '0;
      forward_a_o <= SEL_RF;
      forward_b_o <= SEL_RF;
      stall_cnt_o <= '0;
    end else begin
      exmem_q <= '{v: idex_q.v, rd: idex_q.rd, regwrite: idex_q.regwrite};

      if (load_bubble) begin
        idex_q <= IDEX_BUBBLE;
      end else begin
        idex_q <= '{v: 1'b1, rd: id_rd_i, regwrite: id_regwrite_i, memread: id_memread_i};
      end

      forward_a_o <= fwd_a_d;
      forward_b_o <= fwd_b_d;

      if (stall_o && (stall_cnt_o != {CNT_W{1'b1}}))
        stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl; a second instance with CNT_W=2 shares the
// stimulus to exercise counter saturation.
module tb_fwd_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_memread;
  logic        flush;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        stall;
  logic [15:0] stall_cnt;
  logic [1:0]  fwd_a2;
  logic [1:0]  fwd_b2;
  logic        stall2;
  logic [1:0]  stall_cnt2;

  int total = 0;
  int bad   = 0;

  fwd_hazard_ctrl #(.CNT_W(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .id_valid_i   (id_valid),
    .id_rs1_i     (id_rs1),
    .id_rs2_i     (id_rs2),
    .id_rd_i      (id_rd),
    .id_regwrite_i(id_regwrite),
    .id_memread_i (id_memread),
    .flush_i      (flush),
    .forward_a_o  (fwd_a),
    .forward_b_o  (fwd_b),
    .stall_o      (stall),
    .stall_cnt_o  (stall_cnt)
  );

  fwd_hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .id_valid_i   (id_valid),
    .id_rs1_i     (id_rs1),
    .id_rs2_i     (id_rs2),
    .id_rd_i      (id_rd),
    .id_regwrite_i(id_regwrite),
    .id_memread_i (id_memread),
    .flush_i      (flush),
    .forward_a_o  (fwd_a2),
    .forward_b_o  (fwd_b2),
    .stall_o      (stall2),
    .stall_cnt_o  (stall_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one ID-stage instruction and let combinational outputs settle.
  task automatic put(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
    id_valid    = v;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
    flush       = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    put(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #12;
    check("reset_fwd_a", 16'(fwd_a), 16'd0);
    check("reset_fwd_b", 16'(fwd_b), 16'd0);
    check("reset_stall", 16'(stall), 16'd0);
    check("reset_cnt",   stall_cnt,  16'd0);
    rst_n = 1'b1;
    tick();

    // Back-to-back ALU dependency: add x5 ; sub rs1=5 rs2=6
    put(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
    check("alu_add_stall", 16'(stall), 16'd0);
    tick();
    put(1'b1, 5'd5, 5'd6, 5'd8, 1'b1, 1'b0, 1'b0);
    check("alu_sub_stall", 16'(stall), 16'd0);
    tick();
    check("alu_fwd_a", 16'(fwd_a), 16'd2);
    check("alu_fwd_b", 16'(fwd_b), 16'd0);
    put(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();

    // Two writers to x7 then reader: youngest (EX/MEM) wins
    put(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    put(1'b1, 5'd3, 5'd4, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    put(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("prio_fwd_a", 16'(fwd_a), 16'd2);
    check("prio_fwd_b", 16'(fwd_b), 16'd2);

    // Writer x7, unrelated, reader: MEM/WB forward
    put(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    put(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 1'b0, 1'b0);
    tick();
    check("unrel_fwd_a", 16'(fwd_a), 16'd0);
    check("unrel_fwd_b", 16'(fwd_b), 16'd0);
    put(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("dist2_fwd_a", 16'(fwd_a), 16'd1);
    check("dist2_fwd_b", 16'(fwd_b), 16'd1);
    put(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();

    // Load-use: lw x9 ; add rs1=4 rs2=9 held valid
    put(1'b1, 5'd2, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0);
    check("lu_lw_stall", 16'(stall), 16'd0);
    tick();
    put(1'b1, 5'd4, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0);
    check("lu_stall_hi", 16'(stall), 16'd1);
    check("lu_cnt_before", stall_cnt, 16'd0);
    tick();
    check("lu_stall_drop", 16'(stall), 16'd0);
    check("lu_cnt_after", stall_cnt, 16'd1);
    check("lu_bubble_fwd_a", 16'(fwd_a), 16'd0);
    check("lu_bubble_fwd_b", 16'(fwd_b), 16'd0);
    tick();
    check("lu_fwd_a", 16'(fwd_a), 16'd0);
    check("lu_fwd_b", 16'(fwd_b), 16'd1);
    check("lu_cnt_hold", stall_cnt, 16'd1);

    // x0: load to x0 then reader of x0
    put(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    put(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    check("x0_stall", 16'(stall), 16'd0);
    tick();
    check("x0_fwd_a", 16'(fwd_a), 16'd0);
    check("x0_fwd_b", 16'(fwd_b), 16'd0);

    // Invalid ID slot whose fields match a load in IDEX
    put(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    put(1'b0, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
    check("inv_stall", 16'(stall), 16'd0);
    tick();
    check("inv_fwd_a", 16'(fwd_a), 16'd0);
    check("inv_fwd_b", 16'(fwd_b), 16'd0);
    check("inv_cnt", stall_cnt, 16'd1);

    // Flush beats stall
    put(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0);
    tick();
    put(1'b1, 5'd3, 5'd1, 5'd4, 1'b1, 1'b0, 1'b1);
    check("flush_stall", 16'(stall), 16'd0);
    tick();
    check("flush_cnt", stall_cnt, 16'd1);
    check("flush_fwd_a", 16'(fwd_a), 16'd0);
    check("flush_fwd_b", 16'(fwd_b), 16'd0);

    // Three more load-use pairs: 4 stalls total
    for (int i = 0; i < 3; i++) begin
      put(1'b1, 5'd2, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0);
      tick();
      put(1'b1, 5'd9, 5'd4, 5'd10, 1'b1, 1'b0, 1'b0);
      check("loop_stall_hi", 16'(stall), 16'd1);
      tick();
      tick();
      check("loop_fwd_a", 16'(fwd_a), 16'd1);
    end
    check("cnt16_four", stall_cnt, 16'd4);
    check("cnt2_sat", 16'(stall_cnt2), 16'd3);

    // Async reset mid-stall with a live forward select
    put(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    put(1'b1, 5'd9, 5'd0, 5'd11, 1'b1, 1'b1, 1'b0);
    tick();
    check("pre_rst_fwd_a", 16'(fwd_a), 16'd2);
    put(1'b1, 5'd11, 5'd1, 5'd12, 1'b1, 1'b0, 1'b0);
    check("pre_rst_stall", 16'(stall), 16'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_stall", 16'(stall), 16'd0);
    check("rst_fwd_a", 16'(fwd_a), 16'd0);
    check("rst_fwd_b", 16'(fwd_b), 16'd0);
    check("rst_cnt", stall_cnt, 16'd0);
    check("rst_cnt2", 16'(stall_cnt2), 16'd0);
    #2;
    rst_n = 1'b1;

    // First edge after reset is a normal IDEX load
    put(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    put(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    check("post_rst_fwd_a", 16'(fwd_a), 16'd2);
    check("post_rst_fwd_b", 16'(fwd_b), 16'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
